rtc_display_snapshot: RTL
=========================

Name: rtc_display_snapshot

Overview:
- Parametrised successor to the RTC VGA data latch.
- Captures N_CH packed BCD bytes from the RTC/timer datapath once per frame, at vertical-blanking entry.
- Converts each nibble to ASCII with digit validation into a shadow bank, then commits atomically to a display bank read by the character renderer.
- Also generates a frame-rate-blinking alarm band for the ring indication, replacing the old static colour strip.

Parameters:
- N_CH, 11, number of 8-bit BCD channels (each yields 2 characters).
- V_ACTIVE, 480, first non-visible line; vblank when pixely >= V_ACTIVE.
- BAND_TOP, 473, first line of the alarm band; band covers BAND_TOP..V_ACTIVE inclusive.
- BLINK_FRAMES, 30, frames per blink half-period (1..255).

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high.
- pixely  in  10  current line from SincronizadorVGA.
- datos_in  in  8*N_CH  packed BCD; channel k = datos_in[8k+7:8k], tens in [7:4], units in [3:0].
- freeze  in  1  while high at vblank entry, the capture is skipped and the display bank is held (edit mode).
- ring  in  1  alarm active.
- rd_idx  in  $clog2(2*N_CH)  character index; 2k = units of channel k, 2k+1 = tens.
- rd_char  out  8  ASCII of the display bank at rd_idx (combinational read).
- busy  out  1  high in CAPTURE and COMMIT.
- frame_tick  out  1  one-cycle pulse on each commit.
- alarm_band  out  1  registered; high when the band colour must be shown.

Behaviour:
- vb = (pixely >= V_ACTIVE), registered as vb_q; vb_rise = vb & ~vb_q. Single-cycle event per frame.
- FSM states: IDLE, CAPTURE, COMMIT.
- IDLE:
  - On vb_rise & ~freeze: load the whole datos_in bus into the staging register in that cycle (tear-free snapshot), set ch=0, go to CAPTURE.
  - On vb_rise & freeze: stay in IDLE; no bank change.
- CAPTURE: one channel per cycle from staging.
  - Each nibble n converts to 8'h30+n if n<=9, else 8'h2D ('-').
  - Writes both characters of channel ch into the shadow bank.
  - When ch==N_CH-1, go to COMMIT; otherwise ch+1.
- COMMIT: copy shadow to display bank in one cycle, pulse frame_tick, return to IDLE.
- Latency from the vb_rise cycle to the updated rd_char: N_CH+2 cycles. With defaults, 13 cycles, far below the vblank length.
- datos_in changes after the load cycle do not affect the current snapshot.
- freeze changing after the load cycle has no effect on the capture in progress.
- vb_rise while busy is ignored (no restart, no queue).
- rd_idx >= 2*N_CH returns 8'h20 (space).
- Blink logic:
  - blink_cnt counts vb_rise events 0..BLINK_FRAMES-1 while ring=1.
  - At wrap, blink_cnt returns to 0 and blink_ph toggles.
  - While ring=0: blink_cnt=0 and blink_ph=1, so a new ring is visible on its first frame.
- alarm_band <= ring & blink_ph & (pixely >= BAND_TOP) & (pixely <= V_ACTIVE). One-cycle latency, aligned with the registered rgb path.
- Reset values:
  - FSM in IDLE, ch=0, busy=0, frame_tick=0, alarm_band=0, blink_cnt=0, blink_ph=1, vb_q=1.
  - vb_q=1 suppresses a spurious vb_rise when reset is released in vblank.
  - Staging bank = 0; shadow and display banks = 8'h30 ('0').
- Reset mid-CAPTURE aborts the capture: display bank returns to 8'h30, and no frame_tick is produced.

Decomposition:
- Shared package rtc_disp_pkg: FSM state enum (ST_IDLE, ST_CAPTURE, ST_COMMIT); constants ASCII_ZERO=8'h30, ASCII_DASH=8'h2D, ASCII_SPACE=8'h20.
- One sub-module: bcd_nibble_ascii. Combinational 4-bit to 8-bit converter with validity; two instances in the CAPTURE datapath.

Test Plan:
- Reset, then read all indices -> every rd_char=8'h30; busy=0; alarm_band=0.
- Channel 0=8'h59, channel 2=8'h23, step pixely 479->480 -> busy for 12 cycles, one frame_tick, rd_idx0=8'h39, rd_idx1=8'h35, rd_idx4=8'h33, rd_idx5=8'h32.
- Channel 3=8'hA7 captured -> rd_idx6=8'h37, rd_idx7=8'h2D; rd_idx=22 -> 8'h20.
- freeze=1 at vblank entry with new data -> no busy, no frame_tick, display unchanged; freeze=0 next frame -> update.
- Change datos_in one cycle after vb_rise -> committed data equals the value at vb_rise.
- ring=1, BLINK_FRAMES=2 -> alarm_band high on lines 473..480 in frames 1-2, low in frames 3-4, high in frames 5-6; reset asserted mid-CAPTURE -> banks return to '0', no frame_tick.

Source files
------------

// File: rtl/rtc_disp_pkg.sv
// Shared types and character constants for the RTC display snapshot block.
package rtc_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_COMMIT
    } state_e;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/bcd_nibble_ascii.sv
// Converts one BCD nibble to its ASCII digit; non-decimal codes become a dash.
module bcd_nibble_ascii
    import rtc_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii,
    output logic       valid
);

    always_comb begin
        valid = (nibble <= 4'd9);
        ascii = valid ? (ASCII_ZERO + {4'd0, nibble}) : ASCII_DASH;
    end

endmodule

// File: rtl/rtc_display_snapshot.sv
// Snapshots the packed BCD bus once per frame at vblank entry, converts it to ASCII in a
// shadow bank and commits it atomically to the display bank; also drives the blinking alarm band.
module rtc_display_snapshot
    import rtc_disp_pkg::*;
#(
    parameter int unsigned N_CH         = 11,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned BAND_TOP     = 473,
    parameter int unsigned BLINK_FRAMES = 30,
    localparam int unsigned IDX_W       = $clog2(2 * N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        pixely,
    input  logic [8*N_CH-1:0] datos_in,
    input  logic              freeze,
    input  logic              ring,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [7:0]        rd_char,
    output logic              busy,
    output logic              frame_tick,
    output logic              alarm_band
);

    localparam int unsigned CH_W     = IDX_W - 1;
    localparam logic [9:0]  V_LINE   = 10'(V_ACTIVE);
    localparam logic [9:0]  B_LINE   = 10'(BAND_TOP);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);
    localparam logic [7:0]  BLINK_LAST  = 8'(BLINK_FRAMES - 1);
    localparam logic [IDX_W:0] N_CHARS  = (IDX_W + 1)'(2 * N_CH);

    state_e state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [N_CH-1:0][7:0]   staging_q, staging_d;
    logic [2*N_CH-1:0][7:0] shadow_q, shadow_d;
    logic [2*N_CH-1:0][7:0] display_q, display_d;
    logic       vb, vb_q, vb_rise;
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_ph_q, blink_ph_d;
    logic       alarm_d;
    logic [7:0] units_ascii, tens_ascii;
    logic       units_valid, tens_valid;

    assign vb      = (pixely >= V_LINE);
    assign vb_rise = vb & ~vb_q;

    bcd_nibble_ascii u_units (
        .nibble (staging_q[ch_q][3:0]),
        .ascii  (units_ascii),
        .valid  (units_valid)
    );

    bcd_nibble_ascii u_tens (
        .nibble (staging_q[ch_q][7:4]),
        .ascii  (tens_ascii),
        .valid  (tens_valid)
    );

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        staging_d  = staging_q;
        shadow_d   = shadow_q;
        display_d  = display_q;
        busy       = 1'b0;
        frame_tick = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Whole bus captured in one cycle so later changes cannot tear the frame.
                if (vb_rise && !freeze) begin
                    staging_d = datos_in;
                    ch_d      = '0;
                    state_d   = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                busy = 1'b1;
                shadow_d[{ch_q, 1'b0}] = units_valid ? units_ascii : ASCII_DASH;
                shadow_d[{ch_q, 1'b1}] = tens_valid ? tens_ascii : ASCII_DASH;
                if (ch_q == CH_LAST) begin
                    state_d = ST_COMMIT;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                busy       = 1'b1;
                frame_tick = 1'b1;
                display_d  = shadow_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (!ring) begin
            // Phase parked on so a fresh alarm shows on its very first frame.
            blink_cnt_d = '0;
            blink_ph_d  = 1'b1;
        end else if (vb_rise) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
        alarm_d = ring & blink_ph_q & (pixely >= B_LINE) & (pixely <= V_LINE);
    end

    always_comb begin
        rd_char = ASCII_SPACE;
        if ({1'b0, rd_idx} < N_CHARS) begin
            rd_char = display_q[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            staging_q   <= '0;
            shadow_q    <= {(2 * N_CH){ASCII_ZERO}};
            display_q   <= {(2 * N_CH){ASCII_ZERO}};
            vb_q        <= 1'b1;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b1;
            alarm_band  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            staging_q   <= staging_d;
            shadow_q    <= shadow_d;
            display_q   <= display_d;
            vb_q        <= vb;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            alarm_band  <= alarm_d;
        end
    end

endmodule
